alu_exec_ctrl: RTL and testbench

Multi-cycle execute controller that sits directly in front of the 8-entry register file. It accepts one register-to-register instruction at a time over a valid/ready handshake and reads up to two source operands through the register file's single read port. It computes the ALU result and writes it back to the destination register through the write port. It drives all register-file enables and addresses, and consumes the registered `read_data`.

---
 rtl/alu_exec_pkg.sv | 35 +++
 rtl/alu_exec_alu.sv | 47 ++++
 rtl/alu_exec_ctrl.sv | 156 +++++++++++++++
 tb/tb_alu_exec_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_pkg.sv
// alu_exec_pkg: opcodes, FSM encoding and helpers shared by
// the execute controller and its ALU.
package alu_exec_pkg;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_SHL = 3'd5;
   localparam logic [2:0] OP_MOV = 3'd6;
   localparam logic [2:0] OP_NOT = 3'd7;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RDA  = 3'd1,
      S_RDB  = 3'd2,
      S_EXE  = 3'd3,
      S_WB   = 3'd4
   } state_t;

   typedef struct packed {
      logic [2:0] op;
      logic [2:0] rd;
      logic [2:0] rs1;
      logic [2:0] rs2;
   } instr_t;

   // Unary ops take only operand A; RDB skips the rs2 read.
   function automatic logic is_unary(input logic [2:0] op);
      return (op == OP_SHL) || (op == OP_MOV) ||
             (op == OP_NOT);
   endfunction

endpackage

// File: rtl/alu_exec_alu.sv
// alu_exec_alu: combinational ALU. Ports: i_op, i_a, i_b in;
// o_result (N bits, wraps) and o_carry (ADD carry/SUB borrow/SHL msb).
module alu_exec_alu
   import alu_exec_pkg::*;
#(
   parameter int N = 16
) (
   input  logic [2:0]   i_op,
   input  logic [N-1:0] i_a,
   input  logic [N-1:0] i_b,
   output logic [N-1:0] o_result,
   output logic         o_carry
);

   logic [N:0] w_sum;
   logic [N:0] w_diff;

   assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
   // Bit N of the extended difference is the unsigned borrow.
   assign w_diff = {1'b0, i_a} - {1'b0, i_b};

   always_comb begin
      o_result = '0;
      o_carry  = 1'b0;
      unique case (i_op)
         OP_ADD: begin
            o_result = w_sum[N-1:0];
            o_carry  = w_sum[N];
         end
         OP_SUB: begin
            o_result = w_diff[N-1:0];
            o_carry  = w_diff[N];
         end
         OP_AND: o_result = i_a & i_b;
         OP_OR:  o_result = i_a | i_b;
         OP_XOR: o_result = i_a ^ i_b;
         OP_SHL: begin
            o_result = {i_a[N-2:0], 1'b0};
            o_carry  = i_a[N-1];
         end
         OP_MOV: o_result = i_a;
         OP_NOT: o_result = ~i_a;
         default: o_result = '0;
      endcase
   end

endmodule

// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: 5-state execute controller driving an 8-entry
// register file (one registered read port, one write port).
// Ports: clk, rst (async, active-high); i_instr_valid/o_instr_ready
// handshake with i_instr_op/rd/rs1/rs2; o_rf_read_enable/addr and
// i_rf_read_data; o_rf_write_enable/addr/data; o_done pulse in WB;
// o_flag_zero/o_flag_carry. Flags built only with ALU_EXEC_FLAGS_EN.
module alu_exec_ctrl
   import alu_exec_pkg::*;
#(
   parameter int N = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_instr_valid,
   output logic         o_instr_ready,
   input  logic [2:0]   i_instr_op,
   input  logic [2:0]   i_instr_rd,
   input  logic [2:0]   i_instr_rs1,
   input  logic [2:0]   i_instr_rs2,
   output logic         o_rf_read_enable,
   output logic [2:0]   o_rf_read_addr,
   input  logic [N-1:0] i_rf_read_data,
   output logic         o_rf_write_enable,
   output logic [2:0]   o_rf_write_addr,
   output logic [N-1:0] o_rf_write_data,
   output logic         o_done,
   output logic         o_flag_zero,
   output logic         o_flag_carry
);

   state_t         r_state;
   state_t         w_next;
   instr_t         r_instr;
   logic [N-1:0]   r_a;
   logic [N-1:0]   r_result;
   logic [2:0]     r_rd_addr;
   logic [2:0]     r_wr_addr;
   logic           w_accept;
   logic           w_rd_en;
   logic           w_wr_en;
   logic           w_unary;
   logic [N-1:0]   w_alu_res;

   assign w_unary = is_unary(r_instr.op);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      w_rd_en  = 1'b0;
      w_wr_en  = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (i_instr_valid) begin
               w_accept = 1'b1;
               w_next   = S_RDA;
            end
         end
         S_RDA: begin
            w_rd_en = 1'b1;
            w_next  = S_RDB;
         end
         S_RDB: begin
            w_rd_en = !w_unary;
            w_next  = S_EXE;
         end
         S_EXE: w_next = S_WB;
         S_WB: begin
            w_wr_en = 1'b1;
            w_next  = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Read address is registered so it holds between reads:
   // rs1 is set up at accept, then rs2 (or rs1 again) for RDB.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_instr   <= '0;
         r_rd_addr <= '0;
         r_a       <= '0;
         r_result  <= '0;
         r_wr_addr <= '0;
      end else begin
         if (w_accept) begin
            r_instr   <= '{op:  i_instr_op,
                           rd:  i_instr_rd,
                           rs1: i_instr_rs1,
                           rs2: i_instr_rs2};
            r_rd_addr <= i_instr_rs1;
         end
         if (r_state == S_RDA)
            r_rd_addr <= w_unary ? r_instr.rs1
                                 : r_instr.rs2;
         if (r_state == S_RDB)
            r_a <= i_rf_read_data;
         if (r_state == S_EXE) begin
            r_result  <= w_alu_res;
            r_wr_addr <= r_instr.rd;
         end
      end
   end

`ifdef ALU_EXEC_FLAGS_EN
   logic w_alu_carry;
   logic r_zero;
   logic r_carry;

   alu_exec_alu #(.N(N)) u_alu (
      .i_op     (r_instr.op),
      .i_a      (r_a),
      .i_b      (i_rf_read_data),
      .o_result (w_alu_res),
      .o_carry  (w_alu_carry)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_zero  <= 1'b0;
         r_carry <= 1'b0;
      end else if (r_state == S_EXE) begin
         r_zero  <= (w_alu_res == '0);
         r_carry <= w_alu_carry;
      end
   end

   assign o_flag_zero  = r_zero;
   assign o_flag_carry = r_carry;
`else
   alu_exec_alu #(.N(N)) u_alu (
      .i_op     (r_instr.op),
      .i_a      (r_a),
      .i_b      (i_rf_read_data),
      .o_result (w_alu_res),
      .o_carry  ()
   );

   assign o_flag_zero  = 1'b0;
   assign o_flag_carry = 1'b0;
`endif

   // Ready is forced low while reset is held.
   assign o_instr_ready     = (r_state == S_IDLE) && !rst;
   assign o_rf_read_enable  = w_rd_en;
   assign o_rf_read_addr    = r_rd_addr;
   assign o_rf_write_enable = w_wr_en;
   assign o_rf_write_addr   = r_wr_addr;
   assign o_rf_write_data   = r_result;
   assign o_done            = w_wr_en;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// tb_alu_exec_ctrl: directed bench for alu_exec_ctrl with a
// behavioural register file; flag checks follow ALU_EXEC_FLAGS_EN.
module tb_alu_exec_ctrl;
   import alu_exec_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid = 1'b0;
   logic        ready;
   logic [2:0]  op = '0, rd = '0, rs1 = '0, rs2 = '0;
   logic        re, we, done, fz, fc;
   logic [2:0]  raddr, waddr;
   logic [15:0] rdata = '0;
   logic [15:0] wdata;
   logic [15:0] regs [8];

   int n_chk = 0;
   int n_fail = 0;
   logic prev_z = 1'b0;
   logic prev_c = 1'b0;

   always #5 clk = ~clk;

   alu_exec_ctrl #(.N(16)) dut (
      .clk               (clk),
      .rst               (rst),
      .i_instr_valid     (valid),
      .o_instr_ready     (ready),
      .i_instr_op        (op),
      .i_instr_rd        (rd),
      .i_instr_rs1       (rs1),
      .i_instr_rs2       (rs2),
      .o_rf_read_enable  (re),
      .o_rf_read_addr    (raddr),
      .i_rf_read_data    (rdata),
      .o_rf_write_enable (we),
      .o_rf_write_addr   (waddr),
      .o_rf_write_data   (wdata),
      .o_done            (done),
      .o_flag_zero       (fz),
      .o_flag_carry      (fc)
   );

   // Register file model: registered read, write on the edge.
   always @(posedge clk) begin
      if (re) rdata <= regs[raddr];
      if (we) regs[waddr] <= wdata;
   end

   typedef struct {
      logic [2:0]  op, rd, rs1, rs2;
      logic [15:0] a, b, res;
      logic        z, c;
   } vec_t;

   vec_t vt [12];

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h",
                  name, act, exp);
      end
   endtask

   function automatic logic fl(input logic f);
`ifdef ALU_EXEC_FLAGS_EN
      return f;
`else
      return 1'b0 & f;
`endif
   endfunction

   task automatic run_vec(input vec_t v);
      logic un;
      un = is_unary(v.op);
      regs[v.rs1] = v.a;
      if (v.rs2 != v.rs1) regs[v.rs2] = v.b;
      @(negedge clk);
      op = v.op; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2;
      valid = 1'b1;
      chk("ready_idle", 32'(ready), 32'd1);
      @(negedge clk);
      valid = 1'b0;
      chk("rda_re", 32'(re), 32'd1);
      chk("rda_addr", 32'(raddr), 32'(v.rs1));
      chk("rda_ready", 32'(ready), 32'd0);
      chk("flags_hold", 32'({fz, fc}),
          32'({prev_z, prev_c}));
      @(negedge clk);
      chk("rdb_re", 32'(re), 32'(!un));
      chk("rdb_addr", 32'(raddr),
          32'(un ? v.rs1 : v.rs2));
      chk("rdb_we", 32'(we), 32'd0);
      @(negedge clk);
      chk("exe_ctl", 32'({re, we, done, ready}), 32'd0);
      @(negedge clk);
      chk("wb_we", 32'({we, done}), 32'b11);
      chk("wb_addr", 32'(waddr), 32'(v.rd));
      chk("wb_data", 32'(wdata), 32'(v.res));
      @(negedge clk);
      chk("reg_res", 32'(regs[v.rd]), 32'(v.res));
      chk("idle_ctl", 32'({we, done, ready}), 32'b001);
      chk("wdata_hold", 32'(wdata), 32'(v.res));
      chk("flag_zero", 32'(fz), 32'(fl(v.z)));
      chk("flag_carry", 32'(fc), 32'(fl(v.c)));
      prev_z = fl(v.z);
      prev_c = fl(v.c);
   endtask

   int ts [2];
   int acc;
   int low;

   initial begin
      vt[0]  = '{OP_ADD, 3'd3, 3'd1, 3'd2,
                 16'h0003, 16'h0005, 16'h0008, 1'b0, 1'b0};
      vt[1]  = '{OP_ADD, 3'd4, 3'd1, 3'd2,
                 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1};
      vt[2]  = '{OP_SUB, 3'd6, 3'd2, 3'd1,
                 16'h0001, 16'hFFFF, 16'h0002, 1'b0, 1'b1};
      vt[3]  = '{OP_SHL, 3'd5, 3'd5, 3'd7,
                 16'h8001, 16'h1234, 16'h0002, 1'b0, 1'b1};
      vt[4]  = '{OP_AND, 3'd1, 3'd3, 3'd4,
                 16'hF0F0, 16'hFF00, 16'hF000, 1'b0, 1'b0};
      vt[5]  = '{OP_OR,  3'd2, 3'd3, 3'd4,
                 16'hF0F0, 16'h0F0F, 16'hFFFF, 1'b0, 1'b0};
      vt[6]  = '{OP_XOR, 3'd7, 3'd1, 3'd2,
                 16'hAAAA, 16'hAAAA, 16'h0000, 1'b1, 1'b0};
      vt[7]  = '{OP_MOV, 3'd2, 3'd6, 3'd0,
                 16'h1234, 16'h0000, 16'h1234, 1'b0, 1'b0};
      vt[8]  = '{OP_NOT, 3'd0, 3'd4, 3'd3,
                 16'hFFFF, 16'h0005, 16'h0000, 1'b1, 1'b0};
      vt[9]  = '{OP_SUB, 3'd3, 3'd3, 3'd4,
                 16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0};
      vt[10] = '{OP_SHL, 3'd1, 3'd1, 3'd2,
                 16'h4000, 16'h0000, 16'h8000, 1'b0, 1'b0};
      vt[11] = '{OP_ADD, 3'd0, 3'd7, 3'd7,
                 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1};
      for (int i = 0; i < 8; i++) regs[i] = '0;

      // Reset state
      #12;
      chk("rst_ready", 32'(ready), 32'd0);
      chk("rst_outs", 32'({re, we, done, fz, fc}), 32'd0);
      chk("rst_addr", 32'({raddr, waddr}), 32'd0);
      chk("rst_wdata", 32'(wdata), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rel_ready", 32'(ready), 32'd1);

      for (int i = 0; i < 12; i++) run_vec(vt[i]);

      // Back-to-back with valid held high
      regs[1] = 16'h0003;
      regs[2] = 16'h0005;
      @(negedge clk);
      op = OP_ADD; rd = 3'd3; rs1 = 3'd1; rs2 = 3'd2;
      valid = 1'b1;
      acc = 0;
      low = 0;
      for (int k = 0; k < 30; k++) begin
         if (ready) begin
            ts[acc] = k;
            acc++;
         end else if (acc == 1) begin
            low++;
         end
         if (acc == 2) break;
         @(negedge clk);
         if (acc == 1 && k == ts[0]) begin
            op = OP_XOR; rd = 3'd6;
            rs1 = 3'd3; rs2 = 3'd1;
         end
      end
      chk("b2b_accepts", 32'(acc), 32'd2);
      if (acc == 2) begin
         chk("b2b_spacing", 32'(ts[1] - ts[0]), 32'd5);
         chk("b2b_low", 32'(low), 32'd4);
         @(negedge clk);
         valid = 1'b0;
         repeat (4) @(negedge clk);
         chk("b2b_r3", 32'(regs[3]), 32'h0008);
         chk("b2b_r6", 32'(regs[6]), 32'h000B);
         chk("b2b_ready", 32'(ready), 32'd1);
         prev_z = 1'b0;
         prev_c = 1'b0;
      end else begin
         valid = 1'b0;
         repeat (8) @(negedge clk);
      end

      // Reset during EXE aborts the ADD; make flags nonzero first
      run_vec(vt[11]);
      regs[1] = 16'h0003;
      regs[2] = 16'h0005;
      regs[4] = 16'h5555;
      @(negedge clk);
      op = OP_ADD; rd = 3'd4; rs1 = 3'd1; rs2 = 3'd2;
      valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort_ctl", 32'({re, we, done, ready}), 32'd0);
      chk("abort_flags", 32'({fz, fc}), 32'd0);
      chk("abort_addr", 32'({raddr, waddr}), 32'd0);
      chk("abort_wdata", 32'(wdata), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("abort_ready", 32'(ready), 32'd1);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("abort_no_we", 32'({we, done}), 32'd0);
      end
      chk("abort_r4", 32'(regs[4]), 32'h5555);
      prev_z = 1'b0;
      prev_c = 1'b0;
      run_vec(vt[0]);
      run_vec(vt[1]);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
